// File: rtl/neuron_mac_seq.sv
// Sequential perceptron: streams N_INPUTS weight*input products into a wide accumulator,
// adds a bias, saturates to Q8.8 and hands out one result. Optional ReLU via NEURON_RELU_EN.
module neuron_mac_seq #(
  parameter int                N_INPUTS = 10,
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter int                ACC_W    = 40,
  parameter logic [DATA_W-1:0] BIAS     = '0,
  parameter logic [DATA_W-1:0] THRESH   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_dout,
  input  logic [DATA_W-1:0] x_data,
  input  logic              x_valid,
  output logic              x_ready,
  output logic [DATA_W-1:0] y_data,
  output logic              y_fire,
  output logic              y_valid,
  input  logic              y_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ACC,
    S_FINISH,
    S_OUT
  } state_t;

  localparam int PROD_W = 2 * DATA_W;

  // Bias moved from Q8.8 into the accumulator's Q24.16 grid.
  localparam logic signed [ACC_W-1:0] BIAS_ACC =
    {{(ACC_W-DATA_W-8){BIAS[DATA_W-1]}}, BIAS, 8'h00};
  localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'({1'b0, {(DATA_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] S_MIN = -S_MAX - 1;

  state_t                    state, state_next;
  logic [ADDR_W-1:0]         idx;
  logic signed [ACC_W-1:0]   acc;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   shifted;
  logic signed [DATA_W-1:0]  sat;
  logic [DATA_W-1:0]         y_next;
  logic                      accept;
  logic                      last;

  assign prod    = $signed(rom_dout) * $signed(x_data);
  assign accept  = x_valid && x_ready;
  assign last    = (idx == ADDR_W'(N_INPUTS));
  assign shifted = acc >>> 8;

  always_comb begin
    if (shifted > S_MAX)      sat = S_MAX[DATA_W-1:0];
    else if (shifted < S_MIN) sat = S_MIN[DATA_W-1:0];
    else                      sat = shifted[DATA_W-1:0];
`ifdef NEURON_RELU_EN
    y_next = sat[DATA_W-1] ? '0 : sat;
`else
    y_next = sat;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // NOTE: every signal gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_next = state;
    rom_addr   = '0;
    x_ready    = 1'b0;
    case (state)
      S_IDLE:   if (start) state_next = S_FETCH;
      S_FETCH: begin
        rom_addr   = idx;
        state_next = S_ACC;
      end
      S_ACC: begin
        // Address stays put so the registered ROM output remains this element's weight.
        rom_addr = idx;
        x_ready  = 1'b1;
        if (x_valid) state_next = last ? S_FINISH : S_FETCH;
      end
      S_FINISH: state_next = S_OUT;
      S_OUT:    if (y_ready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= ADDR_W'(1);
      acc     <= '0;
      busy    <= 1'b0;
      y_data  <= '0;
      y_fire  <= 1'b0;
      y_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          acc  <= BIAS_ACC;
          idx  <= ADDR_W'(1);
          busy <= 1'b1;
        end
        S_ACC: if (accept) begin
          acc <= acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
          if (!last) idx <= idx + 1'b1;
        end
        S_FINISH: begin
          y_data  <= y_next;
          y_fire  <= (sat > $signed(THRESH));
          y_valid <= 1'b1;
        end
        S_OUT: if (y_ready) begin
          y_valid <= 1'b0;
          busy    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Randomized bench for neuron_mac_seq against an arithmetic reference model of the neuron.
module tb_neuron_mac_seq;

  localparam int          N       = 10;
  localparam logic [15:0] BIAS    = 16'h0000;
  localparam logic [15:0] THRESH  = 16'h0000;
  localparam int          TIMEOUT = 300;

  logic        clk = 1'b0;
  logic        rst, start, x_valid, x_ready, y_ready;
  logic        busy, y_fire, y_valid;
  logic [15:0] rom_addr, rom_dout, x_data, y_data;

  logic [15:0] w  [0:255];
  logic [15:0] xs [0:N-1];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_dout <= w[rom_addr[7:0]];

  neuron_mac_seq #(
    .N_INPUTS(N), .DATA_W(16), .ADDR_W(16), .ACC_W(40), .BIAS(BIAS), .THRESH(THRESH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .rom_addr(rom_addr), .rom_dout(rom_dout),
    .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
    .y_data(y_data), .y_fire(y_fire), .y_valid(y_valid), .y_ready(y_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Neuron result from the arithmetic definition: bias + dot product, Q8.8 rescale, clamp.
  function automatic void model(output logic [15:0] y, output logic f);
    longint sum, s;
    sum = longint'($signed(BIAS)) * 256;
    for (int k = 1; k <= N; k++)
      sum += longint'($signed(w[k])) * longint'($signed(xs[k-1]));
    s = sum >>> 8;
    if (s > 32767)       s = 32767;
    else if (s < -32768) s = -32768;
    f = (s > longint'($signed(THRESH)));
`ifdef NEURON_RELU_EN
    if (s < 0) s = 0;
`endif
    y = s[15:0];
  endfunction

  task automatic set_ramp();
    w[0] = 16'hDEAD;
    for (int k = 1; k < N; k++) w[k] = 16'(k * 256);
    w[N] = 16'h0000;
  endtask

  task automatic set_x(input logic [15:0] v);
    for (int i = 0; i < N; i++) xs[i] = v;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},     32'(busy),     32'd0);
    check({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
    check({tag, "_x_ready"},  32'(x_ready),  32'd0);
    check({tag, "_y_valid"},  32'(y_valid),  32'd0);
  endtask

  // vmode: 0 = x_valid held high, 1 = toggling, 2 = random.
  task automatic run_neuron(input int vmode, input int rdelay, input bit start_in_wait,
                            input bit start_with_ready, input bit chk_lat);
    int          cyc, ptr;
    bit          hs;
    logic [15:0] ey;
    logic        ef;
    model(ey, ef);
    ptr     = 0;
    y_ready = 1'b0;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc   = 1;
    while (!y_valid && cyc < TIMEOUT) begin
      case (vmode)
        0:       x_valid = 1'b1;
        1:       x_valid = cyc[0];
        default: x_valid = 1'($urandom_range(0, 1));
      endcase
      x_data = (ptr < N) ? xs[ptr] : 16'($urandom);
      hs     = x_valid && x_ready;
      if (x_ready) check("rom_addr_acc", 32'(rom_addr), 32'(ptr + 1));
      @(posedge clk); #1;
      cyc++;
      if (hs) ptr++;
    end
    x_valid = 1'b0;
    if (cyc >= TIMEOUT) check("y_valid_timeout", 32'(cyc), 32'(TIMEOUT - 1));
    if (chk_lat) check("latency", 32'(cyc), 32'(2 * N + 2));
    check("inputs_consumed", 32'(ptr), 32'(N));
    check("y_data", 32'(y_data), 32'(ey));
    check("y_fire", 32'(y_fire), 32'(ef));
    check("busy_out", 32'(busy), 32'd1);
    for (int i = 0; i < rdelay; i++) begin
      start = (start_in_wait && i == 1);
      x_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check("hold_y_valid",  32'(y_valid),  32'd1);
      check("hold_y_data",   32'(y_data),   32'(ey));
      check("hold_y_fire",   32'(y_fire),   32'(ef));
      check("hold_busy",     32'(busy),     32'd1);
      check("hold_rom_addr", 32'(rom_addr), 32'd0);
    end
    x_valid = 1'b0;
    start   = start_with_ready;
    y_ready = 1'b1;
    @(posedge clk); #1;
    y_ready = 1'b0;
    start   = 1'b0;
    check_idle_outputs("consumed");
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("no_second");
  endtask

  task automatic reset_mid_run();
    int ptr, cyc;
    bit hs;
    ptr   = 0;
    cyc   = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    x_valid = 1'b1;
    while (!(ptr == 4 && x_ready) && cyc < TIMEOUT) begin
      x_data = xs[ptr];
      hs     = x_ready;
      @(posedge clk); #1;
      cyc++;
      if (hs) ptr++;
    end
    if (cyc >= TIMEOUT) check("reset_reach_timeout", 32'(cyc), 32'(TIMEOUT - 1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst     = 1'b0;
    x_valid = 1'b0;
    check_idle_outputs("mid_rst");
    check("mid_rst_y_data", 32'(y_data), 32'd0);
    check("mid_rst_y_fire", 32'(y_fire), 32'd0);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    x_valid = 1'b0;
    x_data  = '0;
    y_ready = 1'b0;
    for (int i = 0; i < 256; i++) w[i] = 16'($urandom);
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    check("reset_y_data", 32'(y_data), 32'd0);
    check("reset_y_fire", 32'(y_fire), 32'd0);
    rst = 1'b0;

    set_ramp();
    set_x(16'h0100); run_neuron(0, 0, 1'b0, 1'b0, 1'b1);
    set_x(16'hFF00); run_neuron(0, 0, 1'b0, 1'b0, 1'b1);
    set_x(16'h7FFF); run_neuron(0, 0, 1'b0, 1'b0, 1'b1);
    set_x(16'h8000); run_neuron(0, 0, 1'b0, 1'b0, 1'b1);
    set_x(16'h0100); run_neuron(1, 0, 1'b0, 1'b0, 1'b0);
    set_x(16'h0100); run_neuron(0, 5, 1'b1, 1'b1, 1'b1);

    set_x(16'h0200); run_neuron(0, 0, 1'b0, 1'b0, 1'b0);
    reset_mid_run();
    set_x(16'h0100); run_neuron(0, 0, 1'b0, 1'b0, 1'b1);

    for (int r = 0; r < 20; r++) begin
      for (int k = 1; k <= N; k++)
        w[k] = r[0] ? 16'($urandom) : 16'($urandom_range(0, 16'h03FF) - 16'h0200);
      for (int i = 0; i < N; i++)
        xs[i] = r[1] ? 16'($urandom) : 16'($urandom_range(0, 16'h03FF) - 16'h0200);
      run_neuron(2, $urandom_range(0, 4), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
